// File: rtl/inst_fetch_unit_pkg.sv
// Shared constants, the buffered-instruction record and small helpers for the
// instruction fetch front-end.
package inst_fetch_unit_pkg;

    localparam int unsigned       INST_W       = 32;
    localparam int unsigned       ADDR_W       = 32;
    localparam logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP          = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, core redirect
// and the downstream instruction handshake.
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; the head entry is
// visible combinationally on o_data.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int unsigned   CW   = $clog2(DEPTH + 1);
    localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != FULL) || w_pop);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

    // Storage needs no reset: the count alone says which slots are live.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == LAST) ? '0 : r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == LAST) ? '0 : r_rd + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch front-end: owns the PC, issues credit-limited word fetches, tags them
// with their PC and queues returned instructions for the core.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_VECTOR,
    parameter int unsigned       QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_unit_if.master  io_ifu
);
    localparam int unsigned   CW   = $clog2(QDEPTH + 1);
    localparam logic [CW:0]   QLIM = (CW+1)'(QDEPTH);

    logic [ADDR_W-1:0] r_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_cnt;
    logic [CW-1:0]     w_q_count;
    logic [CW-1:0]     w_tag_count;
    logic [ADDR_W-1:0] w_tag_pc;
    fetch_entry_t      w_q_in;
    fetch_entry_t      w_q_head;
    logic              w_redirect;
    logic              w_rsp;
    logic              w_credit;
    logic              w_issue;
    logic              w_drop_rsp;
    logic              w_q_push;
    logic              w_q_pop;

    assign w_redirect = io_ifu.redirect_valid;
    assign w_rsp      = io_ifu.imem_rvalid;

    // Credit is built from registered counts only, so inst_ready never reaches imem_req.
    assign w_credit   = ({1'b0, w_q_count} + {1'b0, r_outstanding}) < QLIM;
    assign io_ifu.imem_req  = rst_n && !w_redirect && w_credit;
    assign io_ifu.imem_addr = r_pc;
    assign w_issue    = io_ifu.imem_req && io_ifu.imem_ready;

    assign w_drop_rsp = w_rsp && (w_redirect || (r_drop_cnt != '0));
    assign w_q_push   = w_rsp && !w_drop_rsp;
    assign w_q_pop    = io_ifu.inst_valid && io_ifu.inst_ready && !w_redirect;
    assign w_q_in     = {w_tag_pc, io_ifu.imem_rdata};

    assign io_ifu.inst_valid = (w_q_count != '0);
    assign io_ifu.inst       = io_ifu.inst_valid ? w_q_head.inst : NOP;
    assign io_ifu.inst_pc    = io_ifu.inst_valid ? w_q_head.pc   : '0;

    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(QDEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_issue),
        .i_pop   (w_rsp),
        .i_flush (1'b0),
        .i_data  (r_pc),
        .o_data  (w_tag_pc),
        .o_count (w_tag_count)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_inst_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_q_push),
        .i_pop   (w_q_pop),
        .i_flush (w_redirect),
        .i_data  (w_q_in),
        .o_data  (w_q_head),
        .o_count (w_q_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_redirect) begin
                r_pc <= word_align(io_ifu.redirect_pc);
            end else if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end

            case ({w_issue, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: ;
            endcase

            // Everything still in flight at a redirect is stale, bar a response retiring now.
            if (w_redirect) begin
                r_drop_cnt <= r_outstanding - CW'(w_rsp);
            end else if (w_rsp && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    a_rvalid_legal: assert property (@(posedge clk) disable iff (!rst_n)
        w_rsp |-> (r_outstanding != '0));

    a_tags_track: assert property (@(posedge clk) disable iff (!rst_n)
        w_tag_count == r_outstanding);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit: a queue-based model of fetch credit,
// in-flight requests and the instruction buffer predicts every cycle's outputs.
module tb_inst_fetch_unit;

    localparam int unsigned QD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic clk;
    logic rst_n;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_ifu (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit stale; }       flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } slot_t;
    typedef struct { logic [31:0] addr; int unsigned due; } pend_t;

    flight_t     m_fl[$];
    slot_t       m_buf[$];
    pend_t       mem_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] m_pc;
    int unsigned cyc;
    int unsigned last_due;
    int          n_chk;
    int          n_fail;

    int          ready_pct;
    int          lat_max;
    int          rdy_mode;
    int          redir_mode;
    logic [31:0] redir_target;
    bit          fired;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_imem_req"},   bus.imem_req,   1'b0);
        check({tag, "_imem_addr"},  bus.imem_addr,  RPC);
        check({tag, "_inst_valid"}, bus.inst_valid, 1'b0);
        check({tag, "_inst"},       bus.inst,       32'h0);
        check({tag, "_inst_pc"},    bus.inst_pc,    32'h0);
    endtask

    task automatic quiet_inputs();
        bus.imem_ready     = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
    endtask

    task automatic clear_model();
        m_fl.delete();
        m_buf.delete();
        mem_q.delete();
        acc_log.delete();
        m_pc     = RPC;
        last_due = 0;
    endtask

    // One clock: drive at negedge, compare 1 ns later, advance the model at posedge.
    task automatic step();
        bit          r;
        bit          exp_req;
        bit          dreq;
        logic [31:0] daddr;
        @(negedge clk);
        bus.imem_ready = ($urandom_range(99) < ready_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mem_q[0].addr);
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom();
        end
        case (rdy_mode)
            0:       bus.inst_ready = 1'b0;
            1:       bus.inst_ready = 1'b1;
            default: bus.inst_ready = 1'($urandom_range(1));
        endcase
        case (redir_mode)
            1: begin
                r = ($urandom_range(99) < 8);
                redir_target = $urandom();
                if ($urandom_range(3) == 0) redir_target = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            end
            2:       r = !fired && (m_fl.size() == 2);
            3:       r = !fired && bus.imem_rvalid && bus.inst_ready && (m_buf.size() > 0);
            4:       r = !fired;
            default: r = 1'b0;
        endcase
        if (r) fired = 1'b1;
        bus.redirect_valid = r;
        bus.redirect_pc    = redir_target;

        #1;
        exp_req = !r && ((m_buf.size() + m_fl.size()) < QD);
        check("imem_req",   bus.imem_req,   exp_req);
        check("imem_addr",  bus.imem_addr,  m_pc);
        check("inst_valid", bus.inst_valid, m_buf.size() > 0);
        if (m_buf.size() > 0) begin
            check("inst_pc", bus.inst_pc, m_buf[0].pc);
            check("inst",    bus.inst,    m_buf[0].word);
        end
        dreq  = bus.imem_req;
        daddr = bus.imem_addr;

        @(posedge clk);
        cyc++;
        if (r) begin
            if (bus.imem_rvalid && m_fl.size() > 0) void'(m_fl.pop_front());
            foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            m_buf.delete();
            m_pc = redir_target & ~32'h3;
            acc_log.delete();
        end else begin
            if (m_buf.size() > 0 && bus.inst_ready) void'(m_buf.pop_front());
            if (bus.imem_rvalid && m_fl.size() > 0) begin
                flight_t f;
                slot_t   s;
                f = m_fl.pop_front();
                if (!f.stale) begin
                    s.pc   = f.pc;
                    s.word = bus.imem_rdata;
                    m_buf.push_back(s);
                end
            end
            if (exp_req && bus.imem_ready) begin
                flight_t nf;
                nf.pc    = m_pc;
                nf.stale = 1'b0;
                m_fl.push_back(nf);
                m_pc = m_pc + 32'd4;
            end
        end
        if (bus.imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
        if (dreq && bus.imem_ready) begin
            pend_t       p;
            int unsigned due;
            due = cyc + $urandom_range(lat_max - 1);
            if (due < last_due) due = last_due;
            last_due = due;
            p.addr   = daddr;
            p.due    = due;
            mem_q.push_back(p);
            acc_log.push_back(daddr);
        end
    endtask

    task automatic wait_fired(input string tag, input int bound);
        for (int i = 0; i < bound && !fired; i++) step();
        check(tag, fired, 1'b1);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0;
        ready_pct = 100; lat_max = 1; rdy_mode = 1; redir_mode = 0;
        redir_target = '0; fired = 1'b0;
        quiet_inputs();
        clear_model();
        rst_n = 1'b0;
        #1;
        check_reset("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // streaming from reset with a 1-cycle memory
        repeat (20) step();
        check("stream_first_fetch", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, RPC);

        // core stall, then resume
        rdy_mode = 0;
        repeat (5) step();
        rdy_mode = 1;
        repeat (10) step();

        // redirect with two requests in flight
        lat_max = 4; redir_target = 32'h0000_0103; redir_mode = 2; fired = 1'b0;
        wait_fired("redir_two_inflight", 60);
        redir_mode = 0;
        repeat (12) step();
        check("redir_first_fetch", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h100);

        // redirect colliding with a response and a core pop
        lat_max = 1;
        repeat (6) step();
        redir_target = 32'h0000_0200; redir_mode = 3; fired = 1'b0;
        wait_fired("redir_with_rvalid", 60);
        redir_mode = 0;
        repeat (10) step();

        // PC wrap at the top of the address space
        redir_target = 32'hFFFF_FFF8; redir_mode = 4; fired = 1'b0;
        wait_fired("redir_wrap", 4);
        redir_mode = 0;
        repeat (12) step();
        check("wrap_fetch0", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        check("wrap_fetch1", (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_fetch2", (acc_log.size() > 2) ? acc_log[2] : 32'hDEAD_BEEF, 32'h0000_0000);

        // random traffic: memory stalls, variable latency, core back-pressure, redirects
        lat_max = 3; ready_pct = 70; rdy_mode = 2; redir_mode = 1;
        repeat (1500) step();
        redir_mode = 0;

        // asynchronous reset with the queue full
        lat_max = 1; ready_pct = 100; rdy_mode = 0;
        for (int i = 0; i < 40 && m_buf.size() < QD; i++) step();
        check("fill_before_reset", m_buf.size(), QD);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        quiet_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        repeat (10) step();
        check("restart_fetch", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, RPC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
